// File: rtl/axil_wb_master_pkg.sv
// Shared definitions for the AXI-lite to Wishbone classic bridge:
// FSM state encoding, AXI response codes and timeout counter width.
package axil_wb_master_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WR_COLLECT = 3'd1;
   localparam logic [2:0] ST_WB_WR      = 3'd2;
   localparam logic [2:0] ST_WR_RESP    = 3'd3;
   localparam logic [2:0] ST_WB_RD      = 3'd4;
   localparam logic [2:0] ST_RD_RESP    = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [3:0] SEL_ALL = 4'hF;

   // Wide enough for the largest allowed TIMEOUT (1023).
   localparam int TMO_W = 10;

endpackage

// File: rtl/axil_wb_timeout.sv
// Wishbone cycle watchdog: cleared when a cycle starts, counts while the
// cycle runs, and flags expiry in the TIMEOUT-th cycle without ack.
module axil_wb_timeout
   import axil_wb_master_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = en && (count == LAST);

endmodule

// File: rtl/axil_wb_master.sv
// AXI-lite slave to Wishbone classic master bridge, one transaction at a
// time, with round-robin write/read arbitration and an ack timeout.
module axil_wb_master
   import axil_wb_master_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int ADDR_W  = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              wvalid,
   output logic              wready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   output logic              bvalid,
   input  logic              bready,
   output logic [1:0]        bresp,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   output logic              rvalid,
   input  logic              rready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [31:0]       wbm_dat_o,
   input  logic [31:0]       wbm_dat_i,
   input  logic              wbm_ack_i
);

   logic [2:0]        state;
   logic              rr_read;
   logic              have_aw;
   logic              have_w;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [3:0]        strb_q;

   logic              aw_hs;
   logic              w_hs;
   logic              ar_hs;
   logic              contend;
   logic              start_wr;
   logic              wb_busy;
   logic              tmo_expired;
   logic [1:0]        done_resp;

   // Any write activity competing with a read is settled by rr_read
   // (0 = write has priority); the losing side sees its ready low.
   assign contend = (state == ST_IDLE) && (awvalid || wvalid) && arvalid;

   // NOTE: every always_comb output gets a default first so no path can
   // leave a value held, which would infer a latch.
   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      arready = 1'b0;
      if (!wb_rst_i) begin
         case (state)
            ST_IDLE: begin
               awready = !(contend && rr_read);
               wready  = !(contend && rr_read);
               arready = !contend || rr_read;
            end
            ST_WR_COLLECT: begin
               awready = !have_aw;
               wready  = !have_w;
            end
            default: ;
         endcase
      end
   end

   assign aw_hs    = awvalid && awready;
   assign w_hs     = wvalid && wready;
   assign ar_hs    = arvalid && arready;
   assign start_wr = (have_aw || aw_hs) && (have_w || w_hs);
   assign wb_busy  = (state == ST_WB_WR) || (state == ST_WB_RD);

   assign bvalid    = (state == ST_WR_RESP);
   assign rvalid    = (state == ST_RD_RESP);
   assign done_resp = wbm_ack_i ? RESP_OKAY : RESP_SLVERR;

   axil_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .load    (ar_hs || start_wr),
      .en      (wb_busy),
      .expired (tmo_expired)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         rr_read   <= 1'b0;
         have_aw   <= 1'b0;
         have_w    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         bresp     <= RESP_OKAY;
         rresp     <= RESP_OKAY;
         rdata     <= '0;
      end else begin
         if (contend) begin
            rr_read <= !rr_read;
         end
         if (aw_hs) begin
            addr_q <= awaddr;
         end
         if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
         end

         case (state)
            ST_IDLE, ST_WR_COLLECT: begin
               if (ar_hs) begin
                  state     <= ST_WB_RD;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= SEL_ALL;
                  wbm_adr_o <= araddr;
               end else if (start_wr) begin
                  // Channels arriving this very edge bypass the holding registers.
                  state     <= ST_WB_WR;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b1;
                  wbm_sel_o <= w_hs ? wstrb : strb_q;
                  wbm_adr_o <= aw_hs ? awaddr : addr_q;
                  wbm_dat_o <= w_hs ? wdata : data_q;
                  have_aw   <= 1'b0;
                  have_w    <= 1'b0;
               end else if (aw_hs || w_hs) begin
                  state   <= ST_WR_COLLECT;
                  have_aw <= have_aw || aw_hs;
                  have_w  <= have_w || w_hs;
               end
            end
            ST_WB_WR, ST_WB_RD: begin
               if (wbm_ack_i || tmo_expired) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  if (state == ST_WB_WR) begin
                     state <= ST_WR_RESP;
                     bresp <= done_resp;
                  end else begin
                     state <= ST_RD_RESP;
                     rresp <= done_resp;
                     rdata <= wbm_ack_i ? wbm_dat_i : 32'h0;
                  end
               end
            end
            ST_WR_RESP: begin
               if (bready) begin
                  state <= ST_IDLE;
               end
            end
            ST_RD_RESP: begin
               if (rready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_wb_master.sv
// Self-checking bench for axil_wb_master: directed scenarios followed by
// random transactions scored against a byte-level reference memory.
module tb_axil_wb_master;
   import axil_wb_master_pkg::*;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

   always #5 clk = ~clk;

   axil_wb_master #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Wishbone slave: acks after slave_wait wait states, logs every access.
   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
   } wb_rec_t;

   wb_rec_t     wb_log[$];
   logic [31:0] slave_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] r_q[$];
   logic        slave_ack = 1'b0;
   logic [31:0] slave_dat = '0;
   bit          spur_ack = 1'b0;
   bit          slave_never = 1'b0;
   int          slave_wait = 0;
   int          wcnt = 0;

   assign wbm_ack_i = slave_ack | spur_ack;
   assign wbm_dat_i = slave_dat;

   always @(negedge clk) begin
      slave_ack = 1'b0;
      if (wbm_stb_o === 1'b1 && wbm_cyc_o === 1'b1 && !slave_never) begin
         if (wcnt >= slave_wait) begin
            slave_ack = 1'b1;
            wcnt = 0;
            wb_log.push_back('{wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o});
            if (wbm_we_o) begin
               slave_mem[wbm_adr_o] = merge(slave_mem.exists(wbm_adr_o) ? slave_mem[wbm_adr_o] : 32'h0,
                                            wbm_dat_o, wbm_sel_o);
            end else begin
               slave_dat = slave_mem.exists(wbm_adr_o) ? slave_mem[wbm_adr_o] : 32'h0;
            end
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   always @(negedge clk) if (rvalid === 1'b1 && rready === 1'b1) r_q.push_back(rdata);

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
      bit aw_done = 0;
      bit w_done = 0;
      int n = 0;
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge clk);
         awvalid = !aw_done && n >= aw_dly;
         awaddr  = a;
         wvalid  = !w_done && n >= w_dly;
         wdata   = d;
         wstrb   = s;
         #4;
         if (w_done && !aw_done) begin
            check("collect_arready", arready, 0);
            check("collect_wready", wready, 0);
         end
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         @(posedge clk);
         n++;
      end
      if (!(aw_done && w_done)) check("write_handshake_timeout", 0, 1);
      #1;
      awvalid = 0;
      wvalid  = 0;
   endtask

   task automatic axi_read(input logic [31:0] a);
      bit done = 0;
      int n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         arvalid = 1;
         araddr  = a;
         #4;
         if (arready) done = 1;
         @(posedge clk);
         n++;
      end
      if (!done) check("read_handshake_timeout", 0, 1);
      #1;
      arvalid = 0;
   endtask

   task automatic axi_b(input int rdy_dly, output logic [1:0] resp);
      int n = 0;
      while (bvalid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bvalid_seen", bvalid, 1);
      resp = bresp;
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         check("bvalid_held", {bvalid, bresp}, {1'b1, resp});
      end
      @(negedge clk);
      bready = 1;
      @(posedge clk);
      #1;
      bready = 0;
      check("bvalid_drop", bvalid, 0);
   endtask

   task automatic axi_r(input int rdy_dly, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      while (rvalid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rvalid_seen", rvalid, 1);
      data = rdata;
      resp = rresp;
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         check("rvalid_held", {rvalid, rresp, rdata}, {1'b1, resp, data});
      end
      @(negedge clk);
      rready = 1;
      @(posedge clk);
      #1;
      rready = 0;
      check("rvalid_drop", rvalid, 0);
   endtask

   task automatic check_log(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic we);
      wb_rec_t r;
      if (wb_log.size() == 0) begin
         check("wb_log_empty", 0, 1);
      end else begin
         r = wb_log.pop_front();
         check("wb_we", r.we, we);
         check("wb_adr", r.adr, a);
         check("wb_sel", r.sel, s);
         if (we) check("wb_dat", r.dat, d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          hi;

      rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      repeat (2) @(negedge clk);
      check("rst_readies", {awready, wready, arready}, 3'b000);
      rst = 0;
      #1;
      check("idle_readies", {awready, wready, arready}, 3'b111);
      check("rst_valids", {bvalid, rvalid, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 5'b0);
      check("rst_data", {wbm_adr_o, wbm_sel_o, bresp, rresp}, '0);
      check("rst_rdata", rdata, 0);

      // Write with aw and w together, slave acks in the first cycle.
      slave_wait = 0;
      axi_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      check("wr_stb", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b111);
      check("wr_adr", wbm_adr_o, 32'h3000_0010);
      check("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
      check("wr_sel", wbm_sel_o, 4'hF);
      @(posedge clk);
      #1;
      check("wr_bvalid_latency", {bvalid, wbm_cyc_o}, 2'b10);
      axi_b(0, resp);
      check("wr_bresp", resp, RESP_OKAY);
      check("wr_count", wb_log.size(), 1);
      check_log(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1);
      ref_mem[32'h3000_0010] = 32'hDEAD_BEEF;

      // w three cycles ahead of aw.
      axi_write(32'h3000_0080, 32'h5, 4'h3, 3, 0);
      check("late_aw_sel", wbm_sel_o, 4'h3);
      axi_b(0, resp);
      check("late_aw_bresp", resp, RESP_OKAY);
      check("late_aw_count", wb_log.size(), 1);
      check_log(32'h3000_0080, 32'h5, 4'h3, 1);
      ref_mem[32'h3000_0080] = merge(ref_rd(32'h3000_0080), 32'h5, 4'h3);

      // Read with four wait states, rready delayed three cycles.
      slave_mem[32'h3000_0000] = 32'h1234_5678;
      ref_mem[32'h3000_0000]   = 32'h1234_5678;
      slave_wait = 4;
      axi_read(32'h3000_0000);
      check("rd_stb", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, {3'b110, 4'hF});
      axi_r(3, data, resp);
      check("rd_data", data, ref_rd(32'h3000_0000));
      check("rd_resp", resp, RESP_OKAY);
      check_log(32'h3000_0000, 32'h0, 4'hF, 0);

      // Ack while no Wishbone cycle is running.
      spur_ack = 1;
      repeat (3) begin
         @(negedge clk);
         check("spur_ack_quiet", {bvalid, rvalid, wbm_stb_o, awready}, 4'b0001);
      end
      spur_ack = 0;

      // Slave never acks: write then read time out.
      slave_never = 1;
      axi_write(32'h3000_0020, 32'hAAAA_5555, 4'hF, 0, 0);
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wbm_cyc_o !== 1'b1) break;
         hi++;
      end
      check("tmo_cycles", hi, TMO);
      axi_b(0, resp);
      check("tmo_bresp", resp, RESP_SLVERR);
      axi_read(32'h3000_0000);
      axi_r(0, data, resp);
      check("tmo_rresp", {resp, data}, {RESP_SLVERR, 32'h0});
      check("tmo_no_access", wb_log.size(), 0);
      slave_never = 0;
      slave_wait = 1;
      axi_write(32'h3000_0020, 32'h0BAD_F00D, 4'hF, 0, 0);
      axi_b(1, resp);
      check("post_tmo_bresp", resp, RESP_OKAY);
      check_log(32'h3000_0020, 32'h0BAD_F00D, 4'hF, 1);
      ref_mem[32'h3000_0020] = 32'h0BAD_F00D;

      // Simultaneous write and read, two rounds: priority alternates.
      slave_wait = 0;
      bready = 1;
      rready = 1;
      r_q.delete();
      for (int round = 0; round < 2; round++) begin
         d = (round == 0) ? 32'h1111_2222 : 32'h3333_4444;
         fork
            axi_write(32'h3000_0040, d, 4'hF, 0, 0);
            axi_read(32'h3000_0040);
         join
         repeat (8) @(negedge clk);
         check("arb_count", wb_log.size(), 2);
         if (round == 0) begin
            ref_mem[32'h3000_0040] = d;
            check_log(32'h3000_0040, d, 4'hF, 1);
            check_log(32'h3000_0040, 32'h0, 4'hF, 0);
         end else begin
            check_log(32'h3000_0040, 32'h0, 4'hF, 0);
            check_log(32'h3000_0040, d, 4'hF, 1);
         end
         check("arb_reads", r_q.size(), 1);
         if (r_q.size() > 0) check("arb_rdata", r_q.pop_front(), ref_rd(32'h3000_0040));
         if (round == 1) ref_mem[32'h3000_0040] = d;
      end
      bready = 0;
      rready = 0;

      // Reset in the middle of a Wishbone read.
      slave_never = 1;
      axi_read(32'h3000_0000);
      check("rst_mid_stb", wbm_stb_o, 1);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      check("rst_mid_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      @(negedge clk);
      rst = 0;
      slave_never = 0;
      repeat (4) begin
         @(negedge clk);
         check("rst_mid_no_rvalid", rvalid, 0);
      end
      slave_wait = 2;
      axi_write(32'h3000_0050, 32'hCAFE_F00D, 4'h5, 1, 0);
      axi_b(0, resp);
      check("rst_mid_fresh_bresp", resp, RESP_OKAY);
      check_log(32'h3000_0050, 32'hCAFE_F00D, 4'h5, 1);
      ref_mem[32'h3000_0050] = merge(ref_rd(32'h3000_0050), 32'hCAFE_F00D, 4'h5);

      // Random traffic against the reference memory.
      for (int t = 0; t < 24; t++) begin
         a = 32'h3000_0100 + 32'($urandom_range(0, 3)) * 4;
         slave_wait = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2));
            axi_b($urandom_range(0, 2), resp);
            check("rnd_bresp", resp, RESP_OKAY);
            check_log(a, d, s, 1);
            ref_mem[a] = merge(ref_rd(a), d, s);
         end else begin
            axi_read(a);
            axi_r($urandom_range(0, 2), data, resp);
            check("rnd_rresp", resp, RESP_OKAY);
            check("rnd_rdata", data, ref_rd(a));
            check_log(a, 32'h0, 4'hF, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
